// File: rtl/ps2_kbd_queue.sv
// ps2_kbd_queue: PS/2 set-2 scancode prefix decoder feeding a
// first-word-fall-through event FIFO.
// Each event is {ext, brk, code[7:0]}; E0/F0 prefixes fold into the flag bits.
// Optional build macro: PS2_KBD_PAUSE_EN collapses the 8-byte Pause sequence
// (E1 14 77 E1 F0 14 F0 77) into a single event 10'h277. Without it, E1 is
// dropped and the remaining Pause bytes decode as ordinary keys.
module ps2_kbd_queue #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset_ni,
   input  logic [7:0]            ps2_code_i,
   input  logic                  ps2_strobe_i,
   input  logic                  ps2_err_i,
   input  logic                  rd_i,
   output logic [9:0]            data_o,
   output logic                  valid_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  overflow_o,
   input  logic                  clr_ovf_i,
   output logic [7:0]            err_cnt_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_EXT     = 3'd1;
   localparam logic [2:0] ST_BRK     = 3'd2;
   localparam logic [2:0] ST_EXT_BRK = 3'd3;
`ifdef PS2_KBD_PAUSE_EN
   localparam logic [2:0] ST_PAUSE   = 3'd4;
`endif

   // Prefix state and error-edge detection
   logic [2:0] state_q, state_d;
   logic       err_dly_q, err_dly_d;
   logic       err_evt_s;
`ifdef PS2_KBD_PAUSE_EN
   logic [2:0] skip_q, skip_d;
`endif

   // Decoder outputs for an ordinary (non-pause) byte
   logic       ext_s, brk_s;
   logic [2:0] dec_state_s;
   logic       dec_push_s;

   // Event to be pushed this cycle
   logic       push_s;
   logic [9:0] push_data_s;

   // FIFO state
   logic [9:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic                  pop_s, full_s, wr_en_s, ovf_set_s;

   // Error event is the rising edge of the error input
   always_comb begin
      err_dly_d = ps2_err_i;
      err_evt_s = ps2_err_i & ~err_dly_q;
   end

   // Decode one byte against the current prefix flags
   always_comb begin
      ext_s       = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
      brk_s       = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
      dec_state_s = ST_IDLE;
      dec_push_s  = 1'b0;
      case (ps2_code_i)
         8'hE0: dec_state_s = brk_s ? ST_EXT_BRK : ST_EXT;
         8'hF0: dec_state_s = ext_s ? ST_EXT_BRK : ST_BRK;
         default: begin
            dec_state_s = ST_IDLE;
            dec_push_s  = 1'b1;
         end
      endcase
   end

   // Prefix FSM: advances only on a strobe not discarded by an error edge
   always_comb begin
      state_d     = state_q;
      push_s      = 1'b0;
      push_data_s = {ext_s, brk_s, ps2_code_i};
`ifdef PS2_KBD_PAUSE_EN
      skip_d      = skip_q;
`endif
      if (err_evt_s) begin
         state_d = ST_IDLE;
`ifdef PS2_KBD_PAUSE_EN
         skip_d  = 3'd0;
`endif
      end else if (ps2_strobe_i) begin
`ifdef PS2_KBD_PAUSE_EN
         if (state_q == ST_PAUSE) begin
            // Remaining Pause bytes are counted, not decoded
            if (skip_q == 3'd1) begin
               push_s      = 1'b1;
               push_data_s = 10'h277;
               state_d     = ST_IDLE;
               skip_d      = 3'd0;
            end else begin
               skip_d      = skip_q - 3'd1;
            end
         end else if (ps2_code_i == 8'hE1) begin
            state_d = ST_PAUSE;
            skip_d  = 3'd7;
         end else begin
            state_d = dec_state_s;
            push_s  = dec_push_s;
         end
`else
         if (ps2_code_i == 8'hE1) begin
            state_d = state_q;
         end else begin
            state_d = dec_state_s;
            push_s  = dec_push_s;
         end
`endif
      end else begin
         state_d = state_q;
      end
   end

   // FIFO control: pop/push arbitration, count, overflow and error counter
   always_comb begin
      pop_s     = rd_i && (count_q != '0);
      full_s    = (count_q == FULL_CNT);
      wr_en_s   = push_s && (!full_s || pop_s);
      ovf_set_s = push_s && full_s && !pop_s;

      wr_ptr_d  = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d  = pop_s   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      case ({wr_en_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);

      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf_i) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (err_evt_s && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         err_dly_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         err_dly_q <= err_dly_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         err_cnt_q <= err_cnt_d;
      end
   end

`ifdef PS2_KBD_PAUSE_EN
   // Pause skip counter
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         skip_q <= 3'd0;
      end else begin
         skip_q <= skip_d;
      end
   end
`endif

   // Event storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= push_data_s;
      end
   end

   assign data_o     = mem_q[rd_ptr_q];
   assign valid_o    = valid_q;
   assign count_o    = count_q;
   assign overflow_o = ovf_q;
   assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_queue.sv
// Self-checking bench for ps2_kbd_queue (DEPTH_LOG2 = 4).
// Table-driven vectors, hand sequences for FIFO/err corners, and a randomized
// phase checked against a queue-based reference model.
module tb_ps2_kbd_queue;

   localparam int DL    = 4;
   localparam int DEPTH = 1 << DL;

   logic          clk;
   logic          reset_ni;
   logic [7:0]    ps2_code_i;
   logic          ps2_strobe_i;
   logic          ps2_err_i;
   logic          rd_i;
   logic [9:0]    data_o;
   logic          valid_o;
   logic [DL:0]   count_o;
   logic          overflow_o;
   logic          clr_ovf_i;
   logic [7:0]    err_cnt_o;

   ps2_kbd_queue #(.DEPTH_LOG2(DL)) dut (
      .clk          (clk),
      .reset_ni     (reset_ni),
      .ps2_code_i   (ps2_code_i),
      .ps2_strobe_i (ps2_strobe_i),
      .ps2_err_i    (ps2_err_i),
      .rd_i         (rd_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .count_o      (count_o),
      .overflow_o   (overflow_o),
      .clr_ovf_i    (clr_ovf_i),
      .err_cnt_o    (err_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   logic [9:0] m_q[$];
   bit         m_ext, m_brk, m_prev_err, m_ovf;
   int         m_pause, m_ecnt;

   typedef struct {
      logic       stb;
      logic [7:0] code;
      logic       err;
      logic       rd;
      logic       clr;
      logic [DL:0] cnt;
      logic       vld;
      logic [9:0] data;
      logic       ovf;
      logic [7:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic stb, logic [7:0] code, logic err, logic rd,
                               logic clr, int cnt, logic vld, logic [9:0] data,
                               logic ovf, int ecnt);
      vec_t v;
      v.stb = stb; v.code = code; v.err = err; v.rd = rd; v.clr = clr;
      v.cnt = (DL + 1)'(cnt); v.vld = vld; v.data = data; v.ovf = ovf;
      v.ecnt = 8'(ecnt);
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ext = 0; m_brk = 0; m_prev_err = 0; m_ovf = 0;
      m_pause = 0; m_ecnt = 0;
   endtask

   // Behavioural model of one clock edge, from the decoding rules
   task automatic model_step(input logic stb, input logic [7:0] code, input logic err,
                             input logic rd, input logic clr);
      bit         evt, has_push, do_pop, full, ovf_set;
      logic [9:0] ev;
      evt = err && !m_prev_err;
      m_prev_err = err;
      has_push = 0;
      ev = 10'h000;
      if (evt) begin
         m_ext = 0; m_brk = 0; m_pause = 0;
         if (m_ecnt < 255) m_ecnt++;
      end else if (stb) begin
         if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin
               has_push = 1;
               ev = 10'h277;
            end
         end else if (code == 8'hE1) begin
`ifdef PS2_KBD_PAUSE_EN
            m_pause = 7;
`endif
         end else if (code == 8'hE0) begin
            m_ext = 1;
         end else if (code == 8'hF0) begin
            m_brk = 1;
         end else begin
            has_push = 1;
            ev = {m_ext, m_brk, code};
            m_ext = 0; m_brk = 0;
         end
      end
      do_pop  = rd && (m_q.size() > 0);
      full    = (m_q.size() == DEPTH);
      ovf_set = has_push && full && !do_pop;
      if (do_pop) void'(m_q.pop_front());
      if (has_push && !ovf_set) m_q.push_back(ev);
      if (ovf_set) m_ovf = 1;
      else if (clr) m_ovf = 0;
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic step(input logic stb, input logic [7:0] code, input logic err,
                       input logic rd, input logic clr);
      ps2_strobe_i = stb;
      ps2_code_i   = code;
      ps2_err_i    = err;
      rd_i         = rd;
      clr_ovf_i    = clr;
      @(posedge clk);
      #1;
      model_step(stb, code, err, rd, clr);
   endtask

   task automatic byte_in(input logic [7:0] code);
      step(1'b1, code, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_check(input string nm, input logic [9:0] exp);
      check(nm, {22'd0, data_o}, {22'd0, exp});
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && valid_o; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      check("drain_empty", {31'd0, valid_o}, 32'd0);
   endtask

   task automatic do_reset();
      reset_ni = 1'b0;
      #3;
      reset_ni = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [7:0] pause_seq [8];
      ps2_strobe_i = 1'b0; ps2_code_i = 8'h00; ps2_err_i = 1'b0;
      rd_i = 1'b0; clr_ovf_i = 1'b0;
      reset_ni = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_ni = 1'b1;

      // stb, code, err, rd, clr | cnt, vld, data, ovf, ecnt
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 1, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 1, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 2, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 2, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(1, 8'h75, 0, 0, 0, 3, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 3, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 3, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(1, 8'h75, 0, 0, 0, 4, 1, 10'h01C, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 3, 1, 10'h11C, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 2, 1, 10'h275, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 1, 10'h375, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(1, 8'h5A, 0, 0, 0, 1, 1, 10'h05A, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 10'h000, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 10'h000, 0, 1));
      vecs.push_back(mk(1, 8'h75, 0, 0, 0, 1, 1, 10'h075, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 10'h000, 0, 1));
      vecs.push_back(mk(1, 8'h33, 1, 0, 0, 0, 0, 10'h000, 0, 2));
      vecs.push_back(mk(1, 8'h33, 1, 0, 0, 1, 1, 10'h033, 0, 2));
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 10'h000, 0, 2));

      foreach (vecs[i]) begin
         step(vecs[i].stb, vecs[i].code, vecs[i].err, vecs[i].rd, vecs[i].clr);
         check($sformatf("vec%0d_count", i), {27'd0, count_o}, {27'd0, vecs[i].cnt});
         check($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].vld});
         check($sformatf("vec%0d_ovf", i), {31'd0, overflow_o}, {31'd0, vecs[i].ovf});
         check($sformatf("vec%0d_errcnt", i), {24'd0, err_cnt_o}, {24'd0, vecs[i].ecnt});
         if (vecs[i].vld) begin
            check($sformatf("vec%0d_data", i), {22'd0, data_o}, {22'd0, vecs[i].data});
         end
      end

      // Overflow: 17 pushes into a 16-deep FIFO
      for (int i = 0; i < DEPTH + 1; i++) byte_in(8'h50 + 8'(i));
      check("ovf_count", {27'd0, count_o}, 32'd16);
      check("ovf_flag", {31'd0, overflow_o}, 32'd1);
      for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_rd%0d", i), 10'h050 + 10'(i));
      check("ovf_empty", {31'd0, valid_o}, 32'd0);
      check("ovf_sticky", {31'd0, overflow_o}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("ovf_clr", {31'd0, overflow_o}, 32'd0);

      // Clear coinciding with an overflow keeps the flag set
      for (int i = 0; i < DEPTH; i++) byte_in(8'h20 + 8'(i));
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
      check("ovf_clr_same_cycle", {31'd0, overflow_o}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("ovf_clr_after", {31'd0, overflow_o}, 32'd0);

      // Full FIFO: push+pop in the same cycle, alternating with idle cycles
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b1, 1'b0);
         check($sformatf("full_pp%0d_count", i), {27'd0, count_o}, 32'd16);
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      check("full_pp_ovf", {31'd0, overflow_o}, 32'd0);
      for (int k = 0; k < DEPTH; k++) begin
         pop_check($sformatf("full_pp_rd%0d", k),
                   (k < 8) ? (10'h028 + 10'(k)) : (10'h040 + 10'(k - 8)));
      end
      check("full_pp_empty", {31'd0, valid_o}, 32'd0);

      // Pause key sequence
      pause_seq[0] = 8'hE1; pause_seq[1] = 8'h14; pause_seq[2] = 8'h77;
      pause_seq[3] = 8'hE1; pause_seq[4] = 8'hF0; pause_seq[5] = 8'h14;
      pause_seq[6] = 8'hF0; pause_seq[7] = 8'h77;
      for (int i = 0; i < 8; i++) byte_in(pause_seq[i]);
`ifdef PS2_KBD_PAUSE_EN
      check("pause_count", {27'd0, count_o}, 32'd1);
      pop_check("pause_rd", 10'h277);
`else
      check("pause_count", {27'd0, count_o}, 32'd4);
      pop_check("pause_rd0", 10'h014);
      pop_check("pause_rd1", 10'h077);
      pop_check("pause_rd2", 10'h114);
      pop_check("pause_rd3", 10'h177);
`endif
      check("pause_empty", {31'd0, valid_o}, 32'd0);

      // Reset mid-sequence loses the prefix and the FIFO contents
      byte_in(8'h11);
      byte_in(8'hE0);
      do_reset();
      check("rst_count", {27'd0, count_o}, 32'd0);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_errcnt", {24'd0, err_cnt_o}, 32'd0);
      byte_in(8'h75);
      check("rst_next_count", {27'd0, count_o}, 32'd1);
      pop_check("rst_next_data", 10'h075);

      // Randomized phase against the reference model
      begin
         logic       err_lvl;
         logic [7:0] code;
         int         r;
         err_lvl = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 7));
            case (r)
               0: code = 8'hE0;
               1: code = 8'hF0;
               2: code = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5B;
               default: code = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) err_lvl = ~err_lvl;
            step(1'($urandom_range(0, 1)), code, err_lvl,
                 ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
            check("rnd_count", {27'd0, count_o}, m_q.size());
            check("rnd_valid", {31'd0, valid_o}, {31'd0, m_q.size() > 0});
            check("rnd_ovf", {31'd0, overflow_o}, {31'd0, m_ovf});
            check("rnd_errcnt", {24'd0, err_cnt_o}, m_ecnt);
            if (m_q.size() > 0) check("rnd_data", {22'd0, data_o}, {22'd0, m_q[0]});
         end
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end

      // Error counter saturation
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         if (i == 9) check("err_cnt_10", {24'd0, err_cnt_o}, 32'd10);
      end
      check("err_cnt_sat", {24'd0, err_cnt_o}, 32'd255);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
